// File: rtl/display_pkg.sv
// Shared definitions for the debug hex display path.
//   page_e     : which half of the 32-bit value is on the digits
//   SEG_BLANK  : all segments off (active-low)
//   SEG_ZERO   : glyph for "0", used as the reset pattern
//   hex_font() : nibble -> active-low {g,f,e,d,c,b,a} segment pattern
package display_pkg;

  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  function automatic logic [6:0] hex_font(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit decoder.
//   nibble : 4-bit value to show
//   seg    : active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_font(nibble);

endmodule

// File: rtl/hex_display_pager.sv
// Drives six active-low 7-segment digits from a 32-bit debug value,
// paging between LO (bits 23:0) and HI (bits 31:24) by debounced
// button press or auto-scroll timer. freeze holds the displayed snapshot.
//   clk, rst     : clock, async active-high reset
//   value_in     : debug value
//   freeze       : 1 = hold snapshot
//   auto_scroll  : 1 = toggle page every PAGE_CYCLES
//   page_btn     : raw asynchronous push-button
//   hex0..hex5   : registered segment outputs, hex0 rightmost
//   page_led     : 01 = LO page, 10 = HI page
//
// state   | meaning
// PAGE_LO | hex5..hex0 show nibbles 5..0
// PAGE_HI | hex1,hex0 show nibbles 7,6; hex5..hex2 blank
module hex_display_pager
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PAGE_CYCLES     = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        freeze,
  input  logic        auto_scroll,
  input  logic        page_btn,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [1:0]  page_led
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(PAGE_CYCLES - 1);

  logic            btn_meta, btn_sync, btn_level;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip, press, toggle;
  logic [TM_W-1:0] timer;
  logic [31:0]     snapshot;
  page_e           state, state_next;
  logic [3:0]      nib      [6];
  logic [6:0]      seg      [6];
  logic [6:0]      dig_next [6];
  logic [6:0]      dig_q    [6];
  logic [1:0]      led_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= page_btn;
      btn_sync <= btn_meta;
    end
  end

  // Press fires in the same cycle the debounced level is about to rise,
  // so the page flips on the same edge the level is accepted.
  assign db_flip = (btn_sync != btn_level) && (db_cnt == DB_LAST);
  assign press   = db_flip && btn_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else if (btn_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      btn_level <= btn_sync;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // A press coinciding with expiry is still one toggle: both feed one OR.
  assign toggle = press || (auto_scroll && (timer == TM_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (!auto_scroll || toggle) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
    end else if (!freeze) begin
      snapshot <= value_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PAGE_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (toggle) begin
      state_next = (state == PAGE_LO) ? PAGE_HI : PAGE_LO;
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      nib[i] = snapshot[4*i +: 4];
    end
    if (state == PAGE_HI) begin
      nib[0] = snapshot[27:24];
      nib[1] = snapshot[31:28];
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_digit
    hex_to_7seg u_dec (
      .nibble (nib[g]),
      .seg    (seg[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      dig_next[i] = ((state == PAGE_HI) && (i >= 2)) ? SEG_BLANK : seg[i];
    end
    led_next = (state == PAGE_HI) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        dig_q[i] <= SEG_ZERO;
      end
      page_led <= 2'b01;
    end else begin
      for (int i = 0; i < 6; i++) begin
        dig_q[i] <= dig_next[i];
      end
      page_led <= led_next;
    end
  end

  assign hex0 = dig_q[0];
  assign hex1 = dig_q[1];
  assign hex2 = dig_q[2];
  assign hex3 = dig_q[3];
  assign hex4 = dig_q[4];
  assign hex5 = dig_q[5];

endmodule

// File: tb/tb_hex_display_pager.sv
module tb_hex_display_pager;

  logic        clk;
  logic        rst;
  logic [31:0] value_in;
  logic        freeze;
  logic        auto_scroll;
  logic        page_btn;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [1:0]  page_led;

  hex_display_pager #(
    .DEBOUNCE_CYCLES (4),
    .PAGE_CYCLES     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .freeze      (freeze),
    .auto_scroll (auto_scroll),
    .page_btn    (page_btn),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .page_led    (page_led)
  );

  // {hex5,hex4,hex3,hex2,hex1,hex0}
  localparam logic [41:0] ZERO = {6{7'h40}};
  localparam logic [41:0] LO1  = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [41:0] HI1  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24};
  localparam logic [41:0] LO2  = {7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
  localparam logic [41:0] HI2  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h21, 7'h06};

  typedef struct {
    int          cyc;
    logic [41:0] hex;
    logic [1:0]  led;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic push(input int c, input logic [41:0] h, input logic [1:0] l, input string nm);
    exp_t e;
    e.cyc = c; e.hex = h; e.led = l; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: at each falling edge, check every expectation due this cycle.
  initial begin
    exp_t        e;
    logic [41:0] act;
    forever begin
      @(negedge clk);
      act = {hex5, hex4, hex3, hex2, hex1, hex0};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not reached in time (now %0d)", e.name, e.cyc, cyc);
        end else if (act !== e.hex || page_led !== e.led) begin
          errors++;
          $display("FAIL %s @%0d: got hex=%h led=%b, want hex=%h led=%b",
                   e.name, cyc, act, page_led, e.hex, e.led);
        end
      end
      if (done || cyc > 3000) begin
        if (!done) begin
          errors++;
          $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
        end
        if (q.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    int c, e, a, b, f, g;
    rst = 1'b1; value_in = '0; freeze = 1'b0; auto_scroll = 1'b0; page_btn = 1'b0;
    tick(3);

    // 1. reset values and value-to-display latency
    c = cyc;
    push(c, ZERO, 2'b01, "reset");
    rst = 1'b0;
    value_in = 32'h12345678;
    push(c + 1, ZERO, 2'b01, "latency1");
    push(c + 2, LO1, 2'b01, "latency2");
    tick(4);

    // 2. short glitch ignored, held press toggles, release silent
    e = cyc;
    page_btn = 1'b1;
    tick(2);
    page_btn = 1'b0;
    push(e + 10, LO1, 2'b01, "glitch");
    wait_until(e + 12);
    e = cyc;
    page_btn = 1'b1;
    push(e + 6, LO1, 2'b01, "press_pre");
    push(e + 7, HI1, 2'b10, "press_hi");
    wait_until(e + 8);
    page_btn = 1'b0;
    push(e + 30, HI1, 2'b10, "release_silent");
    wait_until(e + 31);

    // 3. auto-scroll every 16 cycles, then hold when disabled
    a = cyc;
    auto_scroll = 1'b1;
    push(a + 16, HI1, 2'b10, "auto_pre1");
    push(a + 17, LO1, 2'b01, "auto_t1");
    push(a + 32, LO1, 2'b01, "auto_pre2");
    push(a + 33, HI1, 2'b10, "auto_t2");
    push(a + 48, HI1, 2'b10, "auto_pre3");
    push(a + 49, LO1, 2'b01, "auto_t3");
    wait_until(a + 49);
    auto_scroll = 1'b0;
    push(a + 90, LO1, 2'b01, "auto_off_hold");
    wait_until(a + 92);

    // 4. press coincides with timer==15 -> single toggle
    b = cyc;
    auto_scroll = 1'b1;
    push(b + 16, LO1, 2'b01, "coinc_pre");
    push(b + 17, HI1, 2'b10, "coinc_single");
    push(b + 32, HI1, 2'b10, "coinc_next_pre");
    push(b + 33, LO1, 2'b01, "coinc_next");
    wait_until(b + 10);
    page_btn = 1'b1;
    wait_until(b + 20);
    page_btn = 1'b0;
    wait_until(b + 34);
    auto_scroll = 1'b0;
    wait_until(b + 36);

    // 5. freeze holds snapshot, unfreeze picks up new value
    f = cyc;
    freeze = 1'b1;
    value_in = 32'hDEADBEEF;
    push(f + 1, LO1, 2'b01, "freeze1");
    push(f + 2, LO1, 2'b01, "freeze2");
    push(f + 5, LO1, 2'b01, "freeze5");
    push(f + 6, LO1, 2'b01, "unfreeze1");
    push(f + 7, LO2, 2'b01, "unfreeze2");
    wait_until(f + 5);
    freeze = 1'b0;
    wait_until(f + 8);

    // 6. reset on HI page mid-dwell, dwell restarts from zero
    g = cyc;
    auto_scroll = 1'b1;
    push(g + 16, LO2, 2'b01, "pre_rst_lo");
    push(g + 17, HI2, 2'b10, "pre_rst_hi");
    push(g + 25, ZERO, 2'b01, "rst_async");
    push(g + 26, ZERO, 2'b01, "rst_held");
    push(g + 27, ZERO, 2'b01, "rst_release");
    push(g + 28, LO2, 2'b01, "post_rst_lo");
    push(g + 42, LO2, 2'b01, "post_rst_pre");
    push(g + 43, HI2, 2'b10, "post_rst_toggle");
    wait_until(g + 25);
    rst = 1'b1;
    wait_until(g + 26);
    rst = 1'b0;
    wait_until(g + 45);
    done = 1'b1;
  end

endmodule
